// File: rtl/trade_pkg.sv
// trade_pkg: signal, position and side encodings, FSM states and order-field helpers
package trade_pkg;
  localparam logic [1:0] SIG_HOLD  = 2'b00;
  localparam logic [1:0] SIG_BUY   = 2'b01;
  localparam logic [1:0] SIG_RSVD  = 2'b10;
  localparam logic [1:0] SIG_SELL  = 2'b11;
  localparam logic [1:0] POS_FLAT  = 2'b00;
  localparam logic [1:0] POS_LONG  = 2'b01;
  localparam logic [1:0] POS_SHORT = 2'b11;
  localparam logic SIDE_BUY  = 1'b0;
  localparam logic SIDE_SELL = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_COOL} state_e;
  function automatic logic sell_side(logic [1:0] pos, logic [1:0] tgt);
    return (tgt == POS_SHORT || (tgt == POS_FLAT && pos == POS_LONG)) ? SIDE_SELL : SIDE_BUY;
  endfunction
  // a move between two open positions is a reversal and needs two units
  function automatic logic [1:0] ord_units(logic [1:0] pos, logic [1:0] tgt);
    return (pos != POS_FLAT && tgt != POS_FLAT) ? 2'd2 : 2'd1;
  endfunction
endpackage

// File: rtl/position_ctrl_if.sv
// position_ctrl_if: signal input, order handshake and status bundle
interface position_ctrl_if;
  logic        sig_valid;
  logic [1:0]  sig_in;
  logic        flat_req;
  logic        ord_valid;
  logic        ord_ready;
  logic        ord_side;
  logic [1:0]  ord_qty;
  logic [1:0]  pos_state;
  logic        busy;
  logic [15:0] drop_cnt;
  modport master (
    output sig_valid, sig_in, flat_req, ord_ready,
    input  ord_valid, ord_side, ord_qty, pos_state, busy, drop_cnt
  );
  modport slave (
    input  sig_valid, sig_in, flat_req, ord_ready,
    output ord_valid, ord_side, ord_qty, pos_state, busy, drop_cnt
  );
endinterface

// File: rtl/sig_confirm.sv
// sig_confirm: confirm counter; POSITION_CTRL_SHORT_EN lets SELL open SHORT, else SELL targets FLAT
module sig_confirm
  import trade_pkg::*;
#(
  parameter int CONFIRM_N = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [1:0] sig_i,
  input  logic [1:0] pos_i,
  output logic       conf_o,
  output logic [1:0] tgt_o
);
  logic [7:0] cnt_q, nxt;
  logic [1:0] last_q;
  logic act;
`ifdef POSITION_CTRL_SHORT_EN
  assign tgt_o = (sig_i == SIG_SELL) ? POS_SHORT : POS_LONG;
`else
  assign tgt_o = (sig_i == SIG_SELL) ? POS_FLAT : POS_LONG;
`endif
  assign act = (sig_i == SIG_BUY || sig_i == SIG_SELL) && tgt_o != pos_i;
  assign nxt = (cnt_q != '0 && last_q == tgt_o) ? cnt_q + 8'd1 : 8'd1;
  assign conf_o = en_i && act && nxt == 8'(CONFIRM_N);
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
      last_q <= rst ? POS_FLAT : last_q;
    end else if (en_i) begin
      cnt_q <= (!act || conf_o) ? 8'd0 : nxt;
      last_q <= act ? tgt_o : last_q;
    end
  end
endmodule

// File: rtl/position_ctrl.sv
// position_ctrl: turns confirmed trading signals into orders; SHORT support via POSITION_CTRL_SHORT_EN
module position_ctrl
  import trade_pkg::*;
#(
  parameter int CONFIRM_N    = 2,
  parameter int COOLDOWN_CYC = 4
) (
  input logic clk,
  input logic rst,
  position_ctrl_if.slave bus
);
  state_e state_q;
  logic [15:0] cd_q, drop_q;
  logic pend_q, oval_q, side_q, busy_q;
  logic [1:0] qty_q, tgt_q, pos_q, conf_tgt, ord_tgt;
  logic idle, close, en, conf, drop;
  assign idle = state_q == ST_IDLE;
  // a pending flatten beats any signal in the same IDLE cycle
  assign close = idle && (pend_q || bus.flat_req) && pos_q != POS_FLAT;
  assign en = idle && bus.sig_valid && !close;
  assign drop = bus.sig_valid && (!idle || close);
  assign ord_tgt = close ? POS_FLAT : conf_tgt;
  sig_confirm #(.CONFIRM_N(CONFIRM_N)) u_confirm (
    .clk(clk),
    .rst(rst),
    .en_i(en),
    .clr_i(close),
    .sig_i(bus.sig_in),
    .pos_i(pos_q),
    .conf_o(conf),
    .tgt_o(conf_tgt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cd_q <= '0;
      drop_q <= '0;
      pend_q <= 1'b0;
      oval_q <= 1'b0;
      side_q <= 1'b0;
      busy_q <= 1'b0;
      qty_q <= '0;
      tgt_q <= POS_FLAT;
      pos_q <= POS_FLAT;
    end else begin
      drop_q <= (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
      case (state_q)
        ST_IDLE: begin
          pend_q <= 1'b0;
          if (close || conf) begin
            state_q <= ST_SEND;
            oval_q <= 1'b1;
            busy_q <= 1'b1;
            tgt_q <= ord_tgt;
            side_q <= sell_side(pos_q, ord_tgt);
            qty_q <= ord_units(pos_q, ord_tgt);
          end
        end
        ST_SEND: begin
          pend_q <= pend_q | bus.flat_req;
          if (bus.ord_ready) begin
            oval_q <= 1'b0;
            pos_q <= tgt_q;
            cd_q <= 16'(COOLDOWN_CYC - 1);
            state_q <= (COOLDOWN_CYC == 0) ? ST_IDLE : ST_COOL;
            busy_q <= COOLDOWN_CYC != 0;
          end
        end
        default: begin
          pend_q <= pend_q | bus.flat_req;
          cd_q <= cd_q - 16'd1;
          state_q <= (cd_q == '0) ? ST_IDLE : ST_COOL;
          busy_q <= cd_q != '0;
        end
      endcase
    end
  end
  assign bus.ord_valid = oval_q;
  assign bus.ord_side = side_q;
  assign bus.ord_qty = qty_q;
  assign bus.pos_state = pos_q;
  assign bus.busy = busy_q;
  assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_position_ctrl.sv
// tb_position_ctrl: directed scenarios plus random stimulus against a transaction-level model
module tb_position_ctrl;
  localparam int CN = 2;
  localparam int CD = 4;
`ifdef POSITION_CTRL_SHORT_EN
  localparam bit SHORT = 1'b1;
`else
  localparam bit SHORT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  position_ctrl_if bus();
  position_ctrl #(.CONFIRM_N(CN), .COOLDOWN_CYC(CD)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [1:0] m_pos, m_otgt, m_qty, m_last;
  logic m_oval, m_side, m_pend;
  int m_cool, m_cnt, m_drop;
  function automatic logic [1:0] target(logic [1:0] si);
    return (si == 2'b11) ? (SHORT ? 2'b11 : 2'b00) : 2'b01;
  endfunction
  function automatic bit m_busy();
    return m_oval || m_cool > 0;
  endfunction
  task automatic model_reset();
    m_pos = 0; m_otgt = 0; m_qty = 0; m_last = 0;
    m_oval = 0; m_side = 0; m_pend = 0;
    m_cool = 0; m_cnt = 0; m_drop = 0;
  endtask
  task automatic issue(input logic [1:0] t);
    m_otgt = t;
    m_oval = 1;
    case ({m_pos, t})
      4'b0001: begin m_side = 0; m_qty = 1; end
      4'b0011: begin m_side = 1; m_qty = 1; end
      4'b0111: begin m_side = 1; m_qty = 2; end
      4'b1101: begin m_side = 0; m_qty = 2; end
      4'b0100: begin m_side = 1; m_qty = 1; end
      4'b1100: begin m_side = 0; m_qty = 1; end
      default: begin m_side = 0; m_qty = 0; end
    endcase
  endtask
  task automatic model_step(input bit sv, input logic [1:0] si, input bit fr, input bit rdy);
    logic [1:0] t;
    bit act;
    if (m_busy()) begin
      if (sv && m_drop < 65535) m_drop++;
      if (fr) m_pend = 1;
      if (m_oval) begin
        if (rdy) begin m_pos = m_otgt; m_oval = 0; m_cool = CD; end
      end else m_cool--;
    end else begin
      bit f;
      f = m_pend || fr;
      m_pend = 0;
      if (f && m_pos != 0) begin
        if (sv && m_drop < 65535) m_drop++;
        m_cnt = 0;
        issue(2'b00);
      end else if (sv) begin
        t = target(si);
        act = (si == 2'b01 || si == 2'b11) && t != m_pos;
        if (!act) m_cnt = 0;
        else begin
          m_cnt = (m_cnt > 0 && m_last == t) ? m_cnt + 1 : 1;
          m_last = t;
          if (m_cnt == CN) begin m_cnt = 0; issue(t); end
        end
      end
    end
  endtask
  task automatic tick(input bit r, input bit sv, input logic [1:0] si, input bit fr, input bit rdy);
    rst = r; bus.sig_valid = sv; bus.sig_in = si; bus.flat_req = fr; bus.ord_ready = rdy;
    @(posedge clk);
    if (r) model_reset(); else model_step(sv, si, fr, rdy);
    @(negedge clk);
  endtask
  task automatic do_reset();
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    rst = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && m_busy(); i++) tick(0, 0, 0, 0, 1);
  endtask
  task automatic go_long();
    tick(0, 1, 2'b01, 0, 0);
    tick(0, 1, 2'b01, 0, 0);
    tick(0, 0, 0, 0, 1);
    drain();
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (bus.ord_valid !== 1'b0) begin errors++; $display("FAIL reset ord_valid got %0b want 0", bus.ord_valid); end
    checks++; if (bus.ord_side !== 1'b0) begin errors++; $display("FAIL reset ord_side got %0b want 0", bus.ord_side); end
    checks++; if (bus.ord_qty !== 2'd0) begin errors++; $display("FAIL reset ord_qty got %0d want 0", bus.ord_qty); end
    checks++; if (bus.pos_state !== 2'b00) begin errors++; $display("FAIL reset pos_state got %b want 00", bus.pos_state); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy got %0b want 0", bus.busy); end
    checks++; if (bus.drop_cnt !== 16'd0) begin errors++; $display("FAIL reset drop_cnt got %0d want 0", bus.drop_cnt); end
  endtask
  task automatic test_buy_open();
    do_reset();
    tick(0, 1, 2'b01, 0, 0);
    checks++; if (bus.ord_valid !== 1'b0) begin errors++; $display("FAIL buy_early ord_valid got %0b want 0", bus.ord_valid); end
    tick(0, 1, 2'b01, 0, 0);
    checks++; if (bus.ord_valid !== 1'b1) begin errors++; $display("FAIL buy ord_valid got %0b want 1", bus.ord_valid); end
    checks++; if ({bus.ord_side, bus.ord_qty} !== 3'b001) begin errors++; $display("FAIL buy side/qty got %0b/%0d want 0/1", bus.ord_side, bus.ord_qty); end
    tick(0, 0, 0, 0, 1);
    checks++; if (bus.pos_state !== 2'b01) begin errors++; $display("FAIL buy pos_state got %b want 01", bus.pos_state); end
  endtask
  task automatic test_cooldown_drops();
    int busy_n;
    do_reset();
    tick(0, 1, 2'b01, 0, 0);
    tick(0, 1, 2'b01, 0, 0);
    tick(0, 1, 2'b11, 0, 0);
    tick(0, 1, 2'b11, 0, 1);
    busy_n = 0;
    for (int i = 0; i < 12 && bus.busy === 1'b1; i++) begin
      busy_n++;
      tick(0, i == 0, 2'b11, 0, 0);
    end
    checks++; if (busy_n != CD) begin errors++; $display("FAIL cooldown busy_cycles got %0d want %0d", busy_n, CD); end
    checks++; if (bus.drop_cnt !== 16'd3) begin errors++; $display("FAIL cooldown drop_cnt got %0d want 3", bus.drop_cnt); end
  endtask
  task automatic test_sell();
    do_reset();
`ifdef POSITION_CTRL_SHORT_EN
    go_long();
    tick(0, 1, 2'b11, 0, 0);
    tick(0, 1, 2'b11, 0, 0);
    for (int i = 0; i < 5; i++) begin
      checks++; if ({bus.ord_valid, bus.ord_side, bus.ord_qty} !== 4'b1110) begin errors++; $display("FAIL reversal_hold cyc %0d got v%0b s%0b q%0d want v1 s1 q2", i, bus.ord_valid, bus.ord_side, bus.ord_qty); end
      tick(0, 0, 0, 0, 0);
    end
    tick(0, 0, 0, 0, 1);
    checks++; if (bus.pos_state !== 2'b11) begin errors++; $display("FAIL reversal pos_state got %b want 11", bus.pos_state); end
`else
    for (int i = 0; i < 3; i++) tick(0, 1, 2'b11, 0, 1);
    checks++; if ({bus.ord_valid, bus.busy, bus.pos_state} !== 4'b0000) begin errors++; $display("FAIL flat_sell got v%0b b%0b p%b want 0 0 00", bus.ord_valid, bus.busy, bus.pos_state); end
    go_long();
    tick(0, 1, 2'b11, 0, 0);
    tick(0, 1, 2'b11, 0, 0);
    checks++; if ({bus.ord_valid, bus.ord_side, bus.ord_qty} !== 4'b1101) begin errors++; $display("FAIL long_sell got v%0b s%0b q%0d want v1 s1 q1", bus.ord_valid, bus.ord_side, bus.ord_qty); end
    tick(0, 0, 0, 0, 1);
    checks++; if (bus.pos_state !== 2'b00) begin errors++; $display("FAIL long_sell pos_state got %b want 00", bus.pos_state); end
`endif
  endtask
  task automatic test_flat_vs_signal();
    logic [15:0] d0;
    do_reset();
    go_long();
    tick(0, 1, 2'b11, 0, 0);
    d0 = bus.drop_cnt;
    tick(0, 1, 2'b11, 1, 0);
    checks++; if ({bus.ord_valid, bus.ord_side, bus.ord_qty} !== 4'b1101) begin errors++; $display("FAIL flat_close got v%0b s%0b q%0d want v1 s1 q1", bus.ord_valid, bus.ord_side, bus.ord_qty); end
    checks++; if (bus.drop_cnt !== d0 + 16'd1) begin errors++; $display("FAIL flat_close drop_cnt got %0d want %0d", bus.drop_cnt, d0 + 16'd1); end
    tick(0, 0, 0, 0, 1);
    checks++; if (bus.pos_state !== 2'b00) begin errors++; $display("FAIL flat_close pos_state got %b want 00", bus.pos_state); end
    drain();
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0);
    checks++; if ({bus.ord_valid, bus.busy} !== 2'b00) begin errors++; $display("FAIL flat_noop got v%0b b%0b want 0 0", bus.ord_valid, bus.busy); end
  endtask
  task automatic test_rst_send();
    do_reset();
    tick(0, 1, 2'b01, 0, 0);
    tick(0, 1, 2'b01, 0, 0);
    tick(0, 1, 2'b01, 0, 0);
    tick(1, 0, 0, 0, 0);
    rst = 0;
    checks++; if ({bus.ord_valid, bus.ord_side, bus.ord_qty, bus.pos_state, bus.busy} !== 7'd0) begin errors++; $display("FAIL rst_send got v%0b s%0b q%0d p%b b%0b want all 0", bus.ord_valid, bus.ord_side, bus.ord_qty, bus.pos_state, bus.busy); end
    checks++; if (bus.drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_send drop_cnt got %0d want 0", bus.drop_cnt); end
  endtask
  task automatic test_random();
    int r;
    logic [1:0] si;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 9);
      si = r < 4 ? 2'b01 : r < 8 ? 2'b11 : r == 8 ? 2'b00 : 2'b10;
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, si, $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1);
      checks++; if (bus.ord_valid !== m_oval) begin errors++; $display("FAIL rnd ord_valid cyc %0d got %0b want %0b", c, bus.ord_valid, m_oval); end
      checks++; if (bus.pos_state !== m_pos) begin errors++; $display("FAIL rnd pos_state cyc %0d got %b want %b", c, bus.pos_state, m_pos); end
      checks++; if (bus.busy !== m_busy()) begin errors++; $display("FAIL rnd busy cyc %0d got %0b want %0b", c, bus.busy, m_busy()); end
      checks++; if (bus.drop_cnt !== 16'(m_drop)) begin errors++; $display("FAIL rnd drop_cnt cyc %0d got %0d want %0d", c, bus.drop_cnt, m_drop); end
      if (m_oval) begin
        checks++; if ({bus.ord_side, bus.ord_qty} !== {m_side, m_qty}) begin errors++; $display("FAIL rnd order cyc %0d got s%0b q%0d want s%0b q%0d", c, bus.ord_side, bus.ord_qty, m_side, m_qty); end
      end
      checks++; if (!SHORT && (bus.pos_state === 2'b11 || bus.ord_qty === 2'd2)) begin errors++; $display("FAIL rnd short_disabled cyc %0d got p%b q%0d want no SHORT", c, bus.pos_state, bus.ord_qty); end
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_buy_open();
    test_cooldown_drops();
    test_sell();
    test_flat_vs_signal();
    test_rst_send();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
